// File: rtl/uart_tx_pkg.sv
// Shared types and framing constants for the user-data UART transmitter.
package uart_tx_pkg;

  localparam int unsigned BITS_PER_BYTE = 8;
  localparam logic        START_BIT     = 1'b0;
  localparam logic        STOP_BIT      = 1'b1;
  localparam int unsigned FRAME_BITS    = 10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    ACK
  } state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: wraps every CLKS_PER_BIT enabled cycles and flags the terminal count.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned       CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = en && (cnt_q == CNT_MAX);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_user_data_tx.sv
// Captures a multi-byte user word on a synchronized request, sends it as 8N1 frames,
// then holds a four-phase acknowledge until the request drops.
module uart_user_data_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned NUM_BYTES    = 4
) (
  input  logic                             clk_i,
  input  logic                             resetn_i,
  input  logic                             user_data_val_tx_i,
  input  logic [BITS_PER_BYTE*NUM_BYTES-1:0] user_data_i,
  output logic                             tx_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             ack_o
);

  localparam int unsigned                DATA_W     = BITS_PER_BYTE * NUM_BYTES;
  localparam int unsigned                BYTE_IDX_W = $clog2(NUM_BYTES) + 1;
  localparam logic [BYTE_IDX_W-1:0]      LAST_BYTE  = BYTE_IDX_W'(NUM_BYTES - 1);

  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       shreg_q, shreg_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [BYTE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic                    tx_d, busy_d, done_d, ack_d;
  logic [7:0]              cur_byte;
  logic [2:0]              bit_nxt;
  logic                    baud_en, baud_clr, bit_tick;

  assign cur_byte = shreg_q[7:0];
  assign bit_nxt  = bit_idx_q + 3'd1;
  assign baud_en  = (state_q == START) || (state_q == DATA) || (state_q == STOP);
  assign baud_clr = (state_q == IDLE) && user_data_val_tx_i;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i   (clk_i),
    .resetn_i(resetn_i),
    .en      (baud_en),
    .clr     (baud_clr),
    .tick_c  (bit_tick)
  );

  // Next-state and next-output logic; outputs are registered one cycle later.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    tx_d       = tx_o;
    busy_d     = busy_o;
    done_d     = 1'b0;
    ack_d      = ack_o;

    unique case (state_q)
      IDLE: begin
        tx_d   = STOP_BIT;
        busy_d = 1'b0;
        ack_d  = 1'b0;
        if (user_data_val_tx_i) begin
          state_d    = START;
          shreg_d    = user_data_i;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          tx_d       = START_BIT;
          busy_d     = 1'b1;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = STOP_BIT;
          end else begin
            bit_idx_d = bit_nxt;
            tx_d      = cur_byte[bit_nxt];
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (byte_idx_q < LAST_BYTE) begin
            state_d    = START;
            byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
            shreg_d    = shreg_q >> BITS_PER_BYTE;
            tx_d       = START_BIT;
          end else begin
            state_d = ACK;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ack_d   = 1'b1;
            tx_d    = STOP_BIT;
          end
        end
      end
      ACK: begin
        tx_d   = STOP_BIT;
        busy_d = 1'b0;
        ack_d  = 1'b1;
        if (!user_data_val_tx_i) begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = STOP_BIT;
        busy_d  = 1'b0;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      tx_o       <= STOP_BIT;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      ack_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      tx_o       <= tx_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      ack_o      <= ack_d;
    end
  end

endmodule

// File: tb/tb_uart_user_data_tx.sv
// Scoreboarded bench: two instances (4 clk/bit x 2 bytes, 2 clk/bit x 1 byte) with UART frame monitors.
module tb_uart_user_data_tx;
  import uart_tx_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_a, req_b;
  logic [15:0] data_a;
  logic [7:0]  data_b;
  logic        tx_a, busy_a, done_a, ack_a;
  logic        tx_b, busy_b, done_b, ack_b;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  always #5 clk = ~clk;

  uart_user_data_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(2)) dut_a (
    .clk_i(clk), .resetn_i(resetn), .user_data_val_tx_i(req_a), .user_data_i(data_a),
    .tx_o(tx_a), .busy_o(busy_a), .done_o(done_a), .ack_o(ack_a)
  );

  uart_user_data_tx #(.CLKS_PER_BIT(2), .NUM_BYTES(1)) dut_b (
    .clk_i(clk), .resetn_i(resetn), .user_data_val_tx_i(req_b), .user_data_i(data_b),
    .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b), .ack_o(ack_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic cur_tx(input int id);
    return (id == 0) ? tx_a : tx_b;
  endfunction

  // Decodes every frame on a line, checks its shape cycle by cycle, and pops the expected byte.
  task automatic run_monitor(input int id, input int cpb);
    logic [9:0] bits;
    logic       prev, s, ok, aborted;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (resetn && cur_tx(id) == 1'b0) begin
        bits = '0; ok = 1'b1; aborted = 1'b0; prev = 1'b0;
        for (int k = 0; k < int'(FRAME_BITS) * cpb && !aborted; k++) begin
          if (k != 0) @(negedge clk);
          if (!resetn) aborted = 1'b1;
          else begin
            s = cur_tx(id);
            if (k % cpb == 0) bits = {s, bits[9:1]};
            else if (s !== prev) ok = 1'b0;
            prev = s;
          end
        end
        if (!aborted) begin
          check($sformatf("frame_shape_%0d", id), 32'({ok, bits[0], bits[9]}), 32'(3'b101));
          if ((id == 0 && q_a.size() == 0) || (id == 1 && q_b.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame_%0d: got byte %0h expected no frame", id, bits[8:1]);
          end else begin
            exp_b = (id == 0) ? q_a.pop_front() : q_b.pop_front();
            check($sformatf("byte_%0d", id), 32'(bits[8:1]), 32'(exp_b));
          end
        end
      end
    end
  endtask

  initial run_monitor(0, 4);
  initial run_monitor(1, 2);

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Counts cycles from the first start-bit cycle of dut_a until done_o, optionally dropping inputs.
  task automatic count_to_done_a(input int drop_req_at, input int poke_data_at, output int n);
    n = 0;
    while (!done_a && n < 200) begin
      @(negedge clk);
      n++;
      if (n == drop_req_at) req_a = 1'b0;
      if (n == poke_data_at) data_a = 16'hFFFF;
    end
  endtask

  task automatic start_a(input logic [15:0] d);
    data_a = d;
    q_a.push_back(d[7:0]);
    q_a.push_back(d[15:8]);
    @(posedge clk); #1 req_a = 1'b1;
    @(negedge clk);
    check("pre_capture_tx", 32'(tx_a), 32'(1));
    @(negedge clk);
    check("latency_tx", 32'(tx_a), 32'(0));
    check("latency_busy", 32'(busy_a), 32'(1));
  endtask

  int n;
  int bad;
  logic [19:0] pat;

  initial begin
    resetn = 1'b0; req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("rst_tx", 32'(tx_a), 32'(1));
    check("rst_busy", 32'(busy_a), 32'(0));
    check("rst_done", 32'(done_a), 32'(0));
    check("rst_ack", 32'(ack_a), 32'(0));
    check("rst_tx_b", 32'(tx_b), 32'(1));

    // Basic transfer with payload change two cycles after capture
    start_a(16'hA55A);
    count_to_done_a(0, 2, n);
    check("done_cycles", 32'(n), 32'(80));
    check("ack_at_done", 32'(ack_a), 32'(1));
    check("busy_at_done", 32'(busy_a), 32'(0));
    @(negedge clk);
    check("done_pulse", 32'(done_a), 32'(0));

    // Hold request: ack stays, no retrigger
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!ack_a || busy_a || tx_a !== 1'b1) bad++;
    end
    check("ack_hold", 32'(bad), 32'(0));
    @(posedge clk); #1 req_a = 1'b0;
    @(negedge clk);
    check("ack_before_sample", 32'(ack_a), 32'(1));
    @(negedge clk);
    check("ack_drop", 32'(ack_a), 32'(0));

    // Retrigger after low phase
    start_a(16'h1234);
    count_to_done_a(0, 0, n);
    check("retrig_done_cycles", 32'(n), 32'(80));
    @(posedge clk); #1 req_a = 1'b0;
    repeat (2) @(negedge clk);
    check("retrig_ack_low", 32'(ack_a), 32'(0));

    // Early request drop during byte-1 start bit
    start_a(16'h0F81);
    count_to_done_a(42, 0, n);
    check("early_done_cycles", 32'(n), 32'(80));
    check("early_ack", 32'(ack_a), 32'(1));
    @(negedge clk);
    check("early_ack_one_cycle", 32'(ack_a), 32'(0));
    check("early_idle_busy", 32'(busy_a), 32'(0));
    check("early_idle_tx", 32'(tx_a), 32'(1));

    // Reset during byte-0 data bits
    start_a(16'hC33C);
    repeat (10) @(negedge clk);
    check("mid_tx_low_data", 32'(busy_a), 32'(1));
    @(posedge clk); #1 resetn = 1'b0;
    #1;
    check("async_rst_tx", 32'(tx_a), 32'(1));
    check("async_rst_busy", 32'(busy_a), 32'(0));
    check("async_rst_done", 32'(done_a), 32'(0));
    q_a.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1 resetn = 1'b1;
    q_a.push_back(8'h3C);
    q_a.push_back(8'hC3);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_start", 32'(tx_a), 32'(0));
    count_to_done_a(0, 0, n);
    check("post_rst_done_cycles", 32'(n), 32'(80));
    @(posedge clk); #1 req_a = 1'b0;
    repeat (2) @(negedge clk);

    // Minimum parameters: 2 clk/bit, one byte 8'h01
    data_b = 8'h01;
    q_b.push_back(8'h01);
    @(posedge clk); #1 req_b = 1'b1;
    @(negedge clk);
    pat = '0;
    repeat (20) begin
      @(negedge clk);
      pat = {pat[18:0], tx_b};
    end
    check("min_pattern", 32'(pat), 32'(20'b00110000000000000011));
    @(negedge clk);
    check("min_done", 32'(done_b), 32'(1));
    check("min_ack", 32'(ack_b), 32'(1));
    @(posedge clk); #1 req_b = 1'b0;
    repeat (2) @(negedge clk);
    check("min_ack_low", 32'(ack_b), 32'(0));

    repeat (5) @(negedge clk);
    check("q_a_drained", 32'(q_a.size()), 32'(0));
    check("q_b_drained", 32'(q_b.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_user_data_tx.md
# uart_user_data_tx

Downstream consumer of the synchronized user-data request. Once the synchronized request level goes high, the block captures a multi-byte user data word and serializes it onto a UART line as 8N1 frames. It then returns a four-phase acknowledge to the requester. It sits between the two-flop request synchronizer and the board-level UART TX pin.

## Interface
Parameters:
- CLKS_PER_BIT, 434, clk_i cycles per UART bit; legal range ≥ 2 (434 gives 115200 baud at 50 MHz).
- NUM_BYTES, 4, bytes sent per request; legal range 1..16.

Ports:
- clk_i  input  1  single system clock, the same domain as the synchronizer output.
- resetn_i  input  1  reset, asynchronous, active-low.
- user_data_val_tx_i  input  1  synchronized request level, taken from the synchronizer output.
- user_data_i  input  8*NUM_BYTES  payload; the requester holds it stable while the request is high.
- tx_o  output  1  UART serial line; idles high.
- busy_o  output  1  high from the capture cycle through the last stop bit.
- done_o  output  1  one-cycle pulse after the last stop bit completes.
- ack_o  output  1  four-phase acknowledge level.

## Operation
- Single clock, one FSM with states IDLE, START, DATA, STOP, ACK.
- IDLE:
  - tx_o=1, busy_o=0, ack_o=0.
  - If user_data_val_tx_i=1: capture user_data_i into the shift register, clear the byte index, go to START.
- START: drive tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with the bit index at 0.
- DATA:
  - Drive the current bit, LSB first, for CLKS_PER_BIT cycles per bit.
  - After bit 7, go to STOP.
- STOP: drive tx_o=1 for CLKS_PER_BIT cycles. Then:
  - If the byte index is below NUM_BYTES-1: increment it, shift the register right by 8, go to START (no idle gap).
  - Otherwise: pulse done_o, go to ACK.
- Byte order: user_data_i[7:0] is sent first; the byte at [8*NUM_BYTES-1 -: 8] is sent last.
- ACK:
  - ack_o=1, tx_o=1, busy_o=0.
  - Stay in ACK while user_data_val_tx_i=1.
  - When it reads 0, go to IDLE; ack_o falls in the same transition.
- A request that stays high after ACK does not retrigger. A new transfer requires the low phase first.
- Changes to user_data_i after the capture cycle are ignored.

Counter widths:
- Baud counter: $clog2(CLKS_PER_BIT) bits. It counts 0..CLKS_PER_BIT-1, wraps, and produces a one-cycle bit tick at terminal count.
- Bit index: 3 bits.
- Byte index: $clog2(NUM_BYTES)+1 bits.

## Timing
- Reset values: tx_o=1, busy_o=0, done_o=0, ack_o=0, state=IDLE, all counters 0.
- Reset asserted mid-frame: tx_o goes high asynchronously, and the frame is abandoned without a done_o pulse.
- Request latency: if user_data_val_tx_i is sampled high in cycle N (in IDLE), tx_o=0 and busy_o=1 from cycle N+1.
- Frame length: each byte frame is exactly 10*CLKS_PER_BIT cycles.
- Transfer length: from the first start bit to the end of the last stop bit is NUM_BYTES*10*CLKS_PER_BIT cycles.
- done_o is high in the first cycle after the last stop bit. That is the same cycle in which ack_o rises and busy_o falls.
- ack_o deasserts one cycle after user_data_val_tx_i is sampled low in ACK.
- Request falling during START/DATA/STOP: ignored. The transfer completes, and the block then passes through ACK for one cycle.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package uart_tx_pkg holds:
  - the state enum;
  - constants BITS_PER_BYTE=8, START_BIT=1'b0, STOP_BIT=1'b1, FRAME_BITS=10.
- Sub-module uart_baud_tick holds the parameterized CLKS_PER_BIT counter. It has an enable input and a tick output, and is cleared whenever the FSM enters START from IDLE.
- Top level holds the FSM, shift register, and bit/byte indices.

## Test plan
- Basic transfer. Setup: CLKS_PER_BIT=4, NUM_BYTES=2, user_data_i=16'hA55A, request raised.
  - tx_o decodes as 0x5A (bits 0,1,0,1,1,0,1,0), then 0xA5.
  - done_o pulses exactly 80 cycles after tx_o first falls.
  - ack_o rises the same cycle.
- Four-phase handshake. Hold the request high 20 cycles after done_o.
  - ack_o stays 1 and there is no second transfer.
  - Drop the request: ack_o goes 0 one cycle later.
  - Raise it again: a new transfer starts.
- Payload change. Change user_data_i to 16'hFFFF two cycles after capture.
  - The line still carries 0x5A, 0xA5.
- Reset mid-transfer. Assert resetn_i=0 during DATA of byte 0.
  - tx_o=1 immediately, busy_o=0, no done_o pulse.
  - After release with the request high, a full transfer occurs.
- Early request drop. Drop the request during the byte-1 START.
  - Both bytes are sent, done_o pulses, ack_o is high for one cycle, then IDLE.
- Minimum parameters. CLKS_PER_BIT=2, NUM_BYTES=1, data 8'h01.
  - 20-cycle frame; tx_o pattern 0,1,0,0,0,0,0,0,0,1, each value held 2 cycles.
